// File: rtl/ledr_fx_drv.sv
// LEDR output stage: global PWM dimming and per-LED blinking behind a bus-mapped CTRL register.
// Optional LEDR_GAMMA_EN squares the DUTY value before the PWM compare.
module ledr_fx_drv #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] BASE     = 32'hF0000024,
  parameter int              PRESCALE = 5000
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic [9:0]      ledrData,
  output logic [9:0]      LEDR
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic             sel;
  logic             wr;
  logic             rd;
  logic [23:0]      ctrl_rd;

  logic [7:0]       duty_q,      duty_d;
  logic [9:0]       bmask_q,     bmask_d;
  logic [5:0]       brate_q,     brate_d;
  logic [PRE_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic [7:0]       pwm_cnt_q,   pwm_cnt_d;
  logic [5:0]       blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q,  blink_ph_d;
  logic [9:0]       ledr_q,      ledr_d;

  logic             tick;
  logic             frame_end;
  logic             pwm_on;

  assign sel = (ABUS == BASE);
  assign wr  = WE & sel;
  assign rd  = !WE & sel;

  assign ctrl_rd = {brate_q, bmask_q, duty_q};
  assign DBUS    = rd ? {{(BITS-24){1'b0}}, ctrl_rd} : {BITS{1'bz}};

`ifdef LEDR_GAMMA_EN
  logic [7:0] cmp_val_q, cmp_val_d;

  // Perceptual correction: compare threshold is DUTY^2 / 256.
  function automatic logic [7:0] gamma_cmp(input logic [7:0] duty);
    logic [15:0] sq;
    sq = 16'(duty) * 16'(duty);
    return sq[15:8];
  endfunction

  always_comb begin
    cmp_val_d = cmp_val_q;
    if (wr)
      cmp_val_d = gamma_cmp(DBUS[7:0]);
  end

  assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < cmp_val_q);
`else
  assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
`endif

  assign tick      = (pre_cnt_q == PRE_LAST);
  assign frame_end = tick & (pwm_cnt_q == 8'hFF);

  always_comb begin
    duty_d      = duty_q;
    bmask_d     = bmask_q;
    brate_d     = brate_q;
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (frame_end) begin
      if (blink_cnt_q == brate_q) begin
        blink_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end

    // A CTRL write restarts the whole timebase so the blink phase is deterministic.
    if (wr) begin
      duty_d      = DBUS[7:0];
      bmask_d     = DBUS[17:8];
      brate_d     = DBUS[23:18];
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end

    ledr_d = ledrData & {10{pwm_on}} & (~bmask_q | {10{blink_ph_q}});
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      duty_q      <= 8'hFF;
      bmask_q     <= '0;
      brate_q     <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      ledr_q      <= '0;
`ifdef LEDR_GAMMA_EN
      cmp_val_q   <= 8'hFE;
`endif
    end else begin
      duty_q      <= duty_d;
      bmask_q     <= bmask_d;
      brate_q     <= brate_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      ledr_q      <= ledr_d;
`ifdef LEDR_GAMMA_EN
      cmp_val_q   <= cmp_val_d;
`endif
    end
  end

  assign LEDR = ledr_q;

endmodule

// File: tb/tb_ledr_fx_drv.sv
// Scoreboard bench for ledr_fx_drv: stimulus queues expected LEDR/DBUS values per cycle,
// a negedge monitor pops and compares them.
module tb_ledr_fx_drv;

  localparam logic [31:0] BASE = 32'hF0000024;
`ifdef LEDR_GAMMA_EN
  localparam int ON40 = 16;
  localparam int ON80 = 64;
`else
  localparam int ON40 = 64;
  localparam int ON80 = 128;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] abus;
  logic        we;
  logic [9:0]  ledr_in;
  logic [9:0]  ledr_out;
  logic [31:0] tb_dbus;
  logic        tb_drv;
  wire  [31:0] dbus;

  assign dbus = tb_drv ? tb_dbus : 32'bz;
  for (genvar g = 0; g < 32; g++) begin : g_pull
    pullup (dbus[g]);
  end

  ledr_fx_drv #(.BITS(32), .BASE(BASE), .PRESCALE(1)) dut (
    .CLK(clk), .reset(rst), .ABUS(abus), .DBUS(dbus), .WE(we),
    .ledrData(ledr_in), .LEDR(ledr_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_bus;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic expect_at(input int c, input bit is_bus, input logic [31:0] e, input string nm);
    chk_t t;
    t.cyc = c; t.is_bus = is_bus; t.exp = e; t.name = nm;
    sb.push_back(t);
  endtask

  // Monitor: compare every queued expectation that falls due in this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = sb[i].is_bus ? dbus : {22'b0, ledr_out};
        n_vec++;
        if (sb[i].cyc < cyc || act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, sb[i].cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Drive a CTRL write so that wr is sampled on edge 'target' (0 = next edge).
  task automatic bus_write(input int target, input logic [31:0] val, output int wcyc);
    if (target > 0) run_to(target - 1);
    abus = BASE; we = 1'b1; tb_dbus = val; tb_drv = 1'b1;
    step();
    wcyc = cyc;
    we = 1'b0; tb_drv = 1'b0; abus = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] e, input string nm);
    abus = addr; we = 1'b0; tb_drv = 1'b0;
    expect_at(cyc, 1'b1, e, nm);
    #1;
    n_vec++;
    if (dbus !== e) begin
      n_err++;
      $display("FAIL %s_imm cyc=%0d got=%h want=%h", nm, cyc, dbus, e);
    end
    step();
    abus = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    int c;
    rst = 1'b1; abus = 32'h0; we = 1'b0; tb_dbus = 32'h0; tb_drv = 1'b0;
    ledr_in = 10'h2A5;

    // Reset behaviour and transparent default.
    step();
    expect_at(1, 1'b0, 32'h0, "rst_ledr1");
    expect_at(2, 1'b0, 32'h0, "rst_ledr2");
    expect_at(3, 1'b0, 32'h0, "rst_ledr3");
    run_to(4);
    rst = 1'b0;
    expect_at(6, 1'b0, 32'h2A5, "pass_ledr6");
    expect_at(7, 1'b0, 32'h2A5, "pass_ledr7");
    run_to(7);
    bus_read(BASE, 32'h000000FF, "rst_readback");

    // PWM at DUTY=0x40.
    ledr_in = 10'h3FF;
    bus_write(0, 32'h00000040, w);
    expect_at(w + 1,          1'b0, 32'h3FF, "pwm40_first_on");
    expect_at(w + 2,          1'b0, 32'h3FF, "pwm40_on2");
    expect_at(w + ON40,       1'b0, 32'h3FF, "pwm40_last_on");
    expect_at(w + ON40 + 1,   1'b0, 32'h000, "pwm40_first_off");
    expect_at(w + 256,        1'b0, 32'h000, "pwm40_last_off");
    expect_at(w + 257,        1'b0, 32'h3FF, "pwm40_wrap_on");
    expect_at(w + 256 + ON40, 1'b0, 32'h3FF, "pwm40_p2_last_on");
    expect_at(w + 257 + ON40, 1'b0, 32'h000, "pwm40_p2_off");
    run_to(w + 257 + ON40);

    // Blink on LEDR[0] only, BRATE=1, full duty.
    ledr_in = 10'h003;
    bus_write(0, 32'h000401FF, w);
    expect_at(w + 1,    1'b0, 32'h003, "blink_start");
    expect_at(w + 512,  1'b0, 32'h003, "blink_last_on");
    expect_at(w + 513,  1'b0, 32'h002, "blink_first_off");
    expect_at(w + 700,  1'b0, 32'h002, "blink_mid_off");
    expect_at(w + 1024, 1'b0, 32'h002, "blink_last_off");
    expect_at(w + 1025, 1'b0, 32'h003, "blink_back_on");
    run_to(w + 1025);

    // Write colliding with tick and frame_end (pwm_cnt=255, BRATE=0 would toggle phase).
    ledr_in = 10'h3FF;
    bus_write(0, 32'h0003FFFF, w);
    expect_at(w + 1,   1'b0, 32'h3FF, "collide_pre_on");
    expect_at(w + 100, 1'b0, 32'h3FF, "collide_pre_mid");
    bus_write(w + 256, 32'h0003FF80, c);
    expect_at(c + 1,          1'b0, 32'h3FF, "collide_new_frame");
    expect_at(c + ON80,       1'b0, 32'h3FF, "duty80_last_on");
    expect_at(c + ON80 + 1,   1'b0, 32'h000, "duty80_first_off");
    expect_at(c + 256,        1'b0, 32'h000, "duty80_last_off");
    expect_at(c + 257,        1'b0, 32'h000, "collide_ph_off");
    expect_at(c + 513,        1'b0, 32'h3FF, "collide_ph_on");
    expect_at(c + 512 + ON80, 1'b0, 32'h3FF, "collide_p3_last_on");
    expect_at(c + 513 + ON80, 1'b0, 32'h000, "collide_p3_off");
    run_to(c + 513 + ON80);
    bus_read(BASE, 32'h0003FF80, "duty80_readback");

    // Upper bits dropped on write, zero on read; other addresses leave DBUS floating.
    bus_write(0, 32'hFFFFFFFF, w);
    expect_at(w + 1, 1'b0, 32'h3FF, "allones_ledr");
    bus_read(BASE, 32'h00FFFFFF, "allones_readback");
    bus_read(BASE + 32'd4, 32'hFFFFFFFF, "other_addr_hiz");
    bus_read(32'h0, 32'hFFFFFFFF, "zero_addr_hiz");

    // Mid-frame reset.
    c = cyc;
    expect_at(c, 1'b0, 32'h3FF, "pre_reset_on");
    rst = 1'b1;
    expect_at(c + 1, 1'b0, 32'h000, "midreset_ledr");
    step();
    rst = 1'b0;
    expect_at(c + 3, 1'b0, 32'h3FF, "post_reset_ledr");
    run_to(c + 3);
    bus_read(BASE, 32'h000000FF, "post_reset_readback");

    // ledrData change mid-frame takes effect the next cycle.
    c = cyc;
    ledr_in = 10'h155;
    expect_at(c,     1'b0, 32'h3FF, "data_old");
    expect_at(c + 1, 1'b0, 32'h155, "data_new");
    run_to(c + 3);
    n_vec++;
    if (ledr_out !== 10'h155) begin
      n_err++;
      $display("FAIL data_hold_imm cyc=%0d got=%h want=%h", cyc, ledr_out, 10'h155);
    end

    foreach (sb[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s cyc=%0d got=unchecked want=%h", sb[i].name, sb[i].cyc, sb[i].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
